// File: rtl/nine_bit_down_timer_pkg.sv
// Shared lab package for the 9-bit counters: state encoding and default width.
// Imported by the down-timer and shared with the up-counter.
package nine_bit_down_timer_pkg;

  localparam int DEFAULT_WIDTH = 9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nine_bit_down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Emits a one-cycle borrow pulse when an enabled tick finds the count at zero.
module nine_bit_down_timer
  import nine_bit_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ldEn,
  input  logic [WIDTH-1:0] parIn,
  input  logic             start,
  input  logic             stop,
  input  logic             cntEn,
  input  logic             autoReload,
  output logic [WIDTH-1:0] parOut,
  output logic             bOut,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             at_zero;

  assign at_zero = (parOut == '0);

  // Priority: load > stop > start > count. The zero test replaces the
  // decrement, so the count can never wrap to all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      parOut <= '0;
      reload <= '0;
      bOut   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (ldEn) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      parOut <= parIn;
      reload <= parIn;
      bOut   <= 1'b0;
      done   <= 1'b0;
    end else if (stop && state == S_RUN) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      bOut  <= 1'b0;
    end else if (start && state == S_IDLE) begin
      state <= S_RUN;
      busy  <= 1'b1;
      bOut  <= 1'b0;
      done  <= 1'b0;
    end else if (state == S_RUN && cntEn) begin
      if (at_zero) begin
        bOut <= 1'b1;
        if (autoReload) begin
          parOut <= reload;
        end else begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        parOut <= parOut - 1'b1;
        bOut   <= 1'b0;
      end
    end else begin
      bOut <= 1'b0;
    end
  end

endmodule
